// File: rtl/rx_byte_packer_pkg.sv
// Shared types, word-layout constants and word builders for the receive byte packer.
package rx_byte_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DROP,
    ST_HDR_PEND
  } state_e;

  localparam int LEN_MSB      = 63;
  localparam int RATE_LSB     = 40;
  localparam int TRL_FCS_OK   = 0;
  localparam int TRL_OVF      = 1;
  localparam int TRL_ABORT    = 2;
  localparam int FIFO_RESERVE = 2;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } fifo_word_t;

  function automatic logic [63:0] make_header(input logic [15:0] len,
                                              input logic [7:0]  rate,
                                              input logic [31:0] seq);
    logic [63:0] w;
    w                  = '0;
    w[LEN_MSB -: 16]   = len;
    w[RATE_LSB +: 8]   = rate;
    w[31:0]            = seq;
    return w;
  endfunction

  function automatic logic [63:0] make_trailer(input logic [15:0] cnt,
                                               input logic        abort,
                                               input logic        ovf,
                                               input logic        ok);
    logic [63:0] w;
    w                = '0;
    w[LEN_MSB -: 16] = cnt;
    w[TRL_ABORT]     = abort;
    w[TRL_OVF]       = ovf;
    w[TRL_FCS_OK]    = ok;
    return w;
  endfunction

endpackage

// File: rtl/rx_byte_packer_if.sv
// Output word stream toward the DMA/host side: valid/ready with a trailer marker.
interface rx_byte_packer_if;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;

  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/rx_word_fifo.sv
// Synchronous first-word-fall-through FIFO; reading while empty or writing while
// full without a simultaneous read is ignored.
module rx_word_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 65
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   occupancy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_wr, do_rd;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != FULL_CNT) || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy = count_q;

endmodule

// File: rtl/rx_byte_packer.sv
// Packs decoded payload bytes into header/payload/trailer 64-bit words and buffers
// them toward the DMA stream; the byte stream is never stalled, overflow is counted.
module rx_byte_packer
  import rx_byte_packer_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pkt_header_valid_strobe,
  input  logic             pkt_header_valid,
  input  logic [7:0]       pkt_rate,
  input  logic [15:0]      pkt_len,
  input  logic             byte_out_strobe,
  input  logic [7:0]       byte_out,
  input  logic             fcs_out_strobe,
  input  logic             fcs_ok,
  rx_byte_packer_if.master m_if,
  output logic [15:0]      overflow_count
);

  localparam logic [FIFO_DEPTH_LOG2:0] MAX_OCC =
    (FIFO_DEPTH_LOG2 + 1)'((1 << FIFO_DEPTH_LOG2) - FIFO_RESERVE);

  state_e      state_q, state_d;
  logic [31:0] seq_q, seq_d, hdr_seq_q, hdr_seq_d;
  logic [15:0] hdr_len_q, hdr_len_d, byte_cnt_q, byte_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic [7:0]  hdr_rate_q, hdr_rate_d;
  logic [2:0]  lane_q, lane_d;
  logic [63:0] pack_q, pack_d, dw_data_q, dw_data_d;
  logic        dw_req_q, dw_req_d, trl_arm_q, trl_arm_d, trl_req_q, trl_req_d;
  logic        trl_abort_q, trl_abort_d, trl_fcs_q, trl_fcs_d, ovf_q, ovf_d;

  logic                     start, take_start, room_ok, bump_ovf, fifo_wr;
  logic [63:0]              word;
  fifo_word_t               fifo_wdata, fifo_rdata;
  logic                     fifo_rvalid;
  logic [FIFO_DEPTH_LOG2:0] fifo_occ;

  assign start   = pkt_header_valid_strobe && pkt_header_valid;
  assign room_ok = (fifo_occ <= MAX_OCC);

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    hdr_seq_d   = hdr_seq_q;
    hdr_len_d   = hdr_len_q;
    hdr_rate_d  = hdr_rate_q;
    byte_cnt_d  = byte_cnt_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    dw_req_d    = 1'b0;
    dw_data_d   = dw_data_q;
    trl_arm_d   = 1'b0;
    trl_req_d   = trl_arm_q;
    trl_abort_d = trl_abort_q;
    trl_fcs_d   = trl_fcs_q;
    ovf_d       = ovf_q;
    take_start  = 1'b0;
    bump_ovf    = 1'b0;
    fifo_wr     = 1'b0;
    fifo_wdata  = '0;
    word        = pack_q;

    // Single FIFO write port: a payload/flush word, or the trailer one cycle later.
    if (dw_req_q) begin
      if (room_ok) begin
        fifo_wr    = 1'b1;
        fifo_wdata = '{last: 1'b0, data: dw_data_q};
      end else begin
        ovf_d    = 1'b1;
        bump_ovf = !ovf_q;
      end
    end else if (trl_req_q) begin
      fifo_wr    = 1'b1;
      fifo_wdata = '{last: 1'b1,
                     data: make_trailer(byte_cnt_q, trl_abort_q, ovf_q, trl_fcs_q)};
    end

    case (state_q)
      ST_IDLE, ST_DROP: begin
        if (start) take_start = 1'b1;
        else if (fcs_out_strobe) state_d = ST_IDLE;
      end

      ST_HDR_PEND: begin
        if (start) begin
          take_start = 1'b1;
        end else if (!dw_req_q && !trl_req_q && !trl_arm_q) begin
          ovf_d      = 1'b0;
          byte_cnt_d = '0;
          lane_d     = '0;
          pack_d     = '0;
          if (room_ok) begin
            fifo_wr    = 1'b1;
            fifo_wdata = '{last: 1'b0, data: make_header(hdr_len_q, hdr_rate_q, hdr_seq_q)};
            state_d    = ST_PAYLOAD;
          end else begin
            bump_ovf = 1'b1;
            state_d  = ST_DROP;
          end
        end
      end

      ST_PAYLOAD: begin
        if (byte_out_strobe) begin
          word[{lane_q, 3'b000} +: 8] = byte_out;
          byte_cnt_d = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 1'b1;
          lane_d     = lane_q + 1'b1;
          if (lane_q == 3'd7) begin
            dw_req_d  = 1'b1;
            dw_data_d = word;
            pack_d    = '0;
          end else begin
            pack_d = word;
          end
        end
        // End of packet, or a new start that aborts it: flush, then trailer.
        if (fcs_out_strobe || start) begin
          if (lane_d != 3'd0) begin
            dw_req_d  = 1'b1;
            dw_data_d = pack_d;
          end
          pack_d      = '0;
          lane_d      = '0;
          trl_arm_d   = 1'b1;
          trl_abort_d = start;
          trl_fcs_d   = start ? 1'b0 : fcs_ok;
          if (start) take_start = 1'b1;
          else       state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (take_start) begin
      hdr_len_d  = pkt_len;
      hdr_rate_d = pkt_rate;
      hdr_seq_d  = seq_q;
      seq_d      = seq_q + 1'b1;
      state_d    = ST_HDR_PEND;
    end

    ovf_cnt_d = (bump_ovf && (ovf_cnt_q != '1)) ? ovf_cnt_q + 1'b1 : ovf_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      hdr_seq_q   <= '0;
      hdr_len_q   <= '0;
      hdr_rate_q  <= '0;
      byte_cnt_q  <= '0;
      ovf_cnt_q   <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      dw_data_q   <= '0;
      dw_req_q    <= 1'b0;
      trl_arm_q   <= 1'b0;
      trl_req_q   <= 1'b0;
      trl_abort_q <= 1'b0;
      trl_fcs_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      hdr_seq_q   <= hdr_seq_d;
      hdr_len_q   <= hdr_len_d;
      hdr_rate_q  <= hdr_rate_d;
      byte_cnt_q  <= byte_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      dw_data_q   <= dw_data_d;
      dw_req_q    <= dw_req_d;
      trl_arm_q   <= trl_arm_d;
      trl_req_q   <= trl_req_d;
      trl_abort_q <= trl_abort_d;
      trl_fcs_q   <= trl_fcs_d;
      ovf_q       <= ovf_d;
    end
  end

  rx_word_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (65)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (fifo_wr),
    .wr_data   (fifo_wdata),
    .rd_en     (m_if.m_ready),
    .rd_data   (fifo_rdata),
    .rd_valid  (fifo_rvalid),
    .occupancy (fifo_occ)
  );

  assign m_if.m_valid   = fifo_rvalid;
  assign m_if.m_data    = fifo_rdata.data;
  assign m_if.m_last    = fifo_rdata.last;
  assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_rx_byte_packer.sv
// Scoreboard bench for rx_byte_packer: expected words are queued as stimulus is
// driven and compared as the stream hands them off.
module tb_rx_byte_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_header_valid_strobe = 1'b0;
  logic        pkt_header_valid = 1'b0;
  logic [7:0]  pkt_rate = '0;
  logic [15:0] pkt_len = '0;
  logic        byte_out_strobe = 1'b0;
  logic [7:0]  byte_out = '0;
  logic        fcs_out_strobe = 1'b0;
  logic        fcs_ok = 1'b0;
  logic [15:0] overflow_count;

  rx_byte_packer_if s_if ();

  rx_byte_packer #(.FIFO_DEPTH_LOG2(4)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .pkt_header_valid_strobe (pkt_header_valid_strobe),
    .pkt_header_valid        (pkt_header_valid),
    .pkt_rate                (pkt_rate),
    .pkt_len                 (pkt_len),
    .byte_out_strobe         (byte_out_strobe),
    .byte_out                (byte_out),
    .fcs_out_strobe          (fcs_out_strobe),
    .fcs_ok                  (fcs_ok),
    .m_if                    (s_if),
    .overflow_count          (overflow_count)
  );

  always #5 clock = ~clock;

  logic [64:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_seq = '0;
  logic        stall_prev = 1'b0;
  logic [64:0] stall_word = '0;

  function automatic logic [63:0] hdr(input logic [15:0] len, input logic [7:0] rate,
                                      input logic [31:0] seq);
    return {len, rate, 8'h00, seq};
  endfunction

  function automatic logic [63:0] trl(input logic [15:0] cnt, input logic abort,
                                      input logic ovf, input logic ok);
    return {cnt, 45'd0, abort, ovf, ok};
  endfunction

  // Output monitor: hold-stability while stalled, and scoreboard pops on handshake.
  always @(negedge clock) begin
    logic [64:0] got, want;
    if (reset) begin
      stall_prev <= 1'b0;
    end else begin
      got = {s_if.m_last, s_if.m_data};
      if (stall_prev) begin
        total++;
        if ({s_if.m_valid, got} !== {1'b1, stall_word}) begin
          bad++;
          $display("FAIL stall_hold: got valid=%b word=%h want valid=1 word=%h",
                   s_if.m_valid, got, stall_word);
        end
      end
      if (s_if.m_valid && s_if.m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %h want no word", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL stream_word: got last=%b data=%h want last=%b data=%h",
                     got[64], got[63:0], want[64], want[63:0]);
          end
        end
      end
      stall_prev <= s_if.m_valid && !s_if.m_ready;
      stall_word <= got;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_start(input logic [15:0] len, input logic [7:0] rate, input logic hv);
    pkt_header_valid_strobe = 1'b1;
    pkt_header_valid        = hv;
    pkt_len                 = len;
    pkt_rate                = rate;
    tick();
    pkt_header_valid_strobe = 1'b0;
    pkt_header_valid        = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fcs, input logic ok);
    byte_out_strobe = 1'b1;
    byte_out        = b;
    fcs_out_strobe  = fcs;
    fcs_ok          = ok;
    tick();
    byte_out_strobe = 1'b0;
    fcs_out_strobe  = 1'b0;
    fcs_ok          = 1'b0;
  endtask

  task automatic send_fcs(input logic ok);
    fcs_out_strobe = 1'b1;
    fcs_ok         = ok;
    tick();
    fcs_out_strobe = 1'b0;
    fcs_ok         = 1'b0;
  endtask

  // Sends n bytes first, first+1, ... and an FCS; queues the words a packet with
  // room for only 'keep' payload words must produce.
  task automatic send_payload(input int n, input logic [7:0] first, input logic ok,
                              input bit coincide, input int keep);
    logic [63:0] w;
    logic [7:0]  b;
    int          lane;
    int          words;
    bit          ovf;
    w = '0; lane = 0; words = 0; ovf = 0;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      w[lane*8 +: 8] = b;
      lane++;
      if (lane == 8) begin
        if (words < keep) begin exp_q.push_back({1'b0, w}); words++; end
        else ovf = 1;
        w = '0; lane = 0;
      end
      send_byte(b, coincide && (i == n - 1), ok);
    end
    if (lane != 0) begin
      if (words < keep) exp_q.push_back({1'b0, w});
      else ovf = 1;
    end
    exp_q.push_back({1'b1, trl(16'(n), 1'b0, ovf, ok)});
    if (!coincide) send_fcs(ok);
    idle(2);
  endtask

  task automatic run_packet(input int n, input logic [7:0] rate, input logic [7:0] first,
                            input logic ok, input bit coincide, input int keep);
    exp_q.push_back({1'b0, hdr(16'(n), rate, exp_seq)});
    do_start(16'(n), rate, 1'b1);
    exp_seq++;
    idle(4);
    send_payload(n, first, ok, coincide, keep);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    idle(4);
  endtask

  task automatic test_reset();
    s_if.m_ready = 1'b1;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    total++;
    if (s_if.m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", s_if.m_valid); end
    total++;
    if (s_if.m_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", s_if.m_last); end
    total++;
    if (s_if.m_data !== 64'd0) begin bad++; $display("FAIL reset_data: got %h want 0", s_if.m_data); end
    total++;
    if (overflow_count !== 16'd0) begin bad++; $display("FAIL reset_ovf_cnt: got %0d want 0", overflow_count); end
  endtask

  task automatic test_basic();
    exp_q.push_back({1'b0, 64'h000A_0B00_0000_0000});
    exp_q.push_back({1'b0, 64'h0807_0605_0403_0201});
    exp_q.push_back({1'b0, 64'h0000_0000_0000_0A09});
    exp_q.push_back({1'b1, 64'h000A_0000_0000_0001});
    do_start(16'd10, 8'h0B, 1'b1);
    exp_seq++;
    idle(4);
    for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_fcs(1'b1);
    drain(100);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL basic_drain: got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_multiple_of_8();
    run_packet(16, 8'h0C, 8'h10, 1'b0, 1'b0, 1000);
    drain(100);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL mult8_drain: got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
    total++;
    if (overflow_count !== 16'd0) begin bad++; $display("FAIL mult8_ovf_cnt: got %0d want 0", overflow_count); end
  endtask

  task automatic test_coincident_and_invalid();
    do_start(16'd7, 8'h77, 1'b0);
    idle(6);
    send_fcs(1'b1);
    idle(6);
    run_packet(11, 8'h0D, 8'hA0, 1'b1, 1'b1, 1000);
    drain(100);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL coinc_drain: got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_mid_packet_start();
    exp_q.push_back({1'b0, hdr(16'd20, 8'h0D, exp_seq)});
    do_start(16'd20, 8'h0D, 1'b1);
    exp_seq++;
    idle(4);
    for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1'b0, 1'b0);
    exp_q.push_back({1'b0, 64'h0000_0035_3433_3231});
    exp_q.push_back({1'b1, trl(16'd5, 1'b1, 1'b0, 1'b0)});
    exp_q.push_back({1'b0, hdr(16'd6, 8'h0E, exp_seq)});
    do_start(16'd6, 8'h0E, 1'b1);
    exp_seq++;
    idle(4);
    send_payload(6, 8'h41, 1'b1, 1'b0, 1000);
    drain(100);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL abort_drain: got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_backpressure_and_full();
    s_if.m_ready = 1'b0;
    run_packet(200, 8'h21, 8'h00, 1'b1, 1'b0, 14);
    idle(2);
    total++;
    if (overflow_count !== 16'd1) begin bad++; $display("FAIL bp_ovf_cnt: got %0d want 1", overflow_count); end
    total++;
    if (s_if.m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", s_if.m_valid); end
    // FIFO now full: this packet must be dropped entirely.
    do_start(16'd8, 8'h22, 1'b1);
    exp_seq++;
    idle(4);
    for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
    send_fcs(1'b1);
    idle(2);
    total++;
    if (overflow_count !== 16'd2) begin bad++; $display("FAIL drop_ovf_cnt: got %0d want 2", overflow_count); end
    s_if.m_ready = 1'b1;
    drain(200);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL bp_drain: got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_payload();
    s_if.m_ready = 1'b0;
    do_start(16'd30, 8'h33, 1'b1);
    idle(4);
    for (int i = 0; i < 3; i++) send_byte(8'h90 + 8'(i), 1'b0, 1'b0);
    idle(1);
    total++;
    if (s_if.m_valid !== 1'b1) begin bad++; $display("FAIL prereset_valid: got %b want 1", s_if.m_valid); end
    reset = 1'b1;
    tick();
    total++;
    if (s_if.m_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", s_if.m_valid); end
    total++;
    if (overflow_count !== 16'd0) begin bad++; $display("FAIL midreset_ovf_cnt: got %0d want 0", overflow_count); end
    reset = 1'b0;
    exp_q.delete();
    exp_seq = '0;
    s_if.m_ready = 1'b1;
    idle(2);
    run_packet(3, 8'h44, 8'h51, 1'b1, 1'b0, 1000);
    drain(100);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL postreset_drain: got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  initial begin
    s_if.m_ready = 1'b1;
    test_reset();
    test_basic();
    test_multiple_of_8();
    test_coincident_and_invalid();
    test_mid_packet_start();
    test_backpressure_and_full();
    test_reset_mid_payload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
